ror_seq: RTL
============

Name: ror_seq

Overview:
- Sequential rotate-right unit for the CPU datapath ALU.
- Rotates a 32-bit operand right by b[4:0] positions, one position per clock, under a start/done handshake.
- Sits beside the combinational rotate-left unit in the ALU and drives the shared result bus.
- Gives the datapath the opposite rotate direction as a multi-cycle operation.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, rotate-amount field width (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand to rotate; captured on accepted start.
- b  input  WIDTH  rotate amount; only b[SHAMT_W-1:0] used; captured on accepted start.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  rotated value.

Behaviour:
- Reset: clk and reset handling is already decided. One clock; reset is synchronous and active-high.
- On clr high at a rising edge: state=IDLE, result=0, busy=0, done=0, internal count=0.
- clr has priority over every other input, including mid-operation. An in-flight operation is aborted with no done pulse.
- State machine: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - acc<=a, cnt<=b[SHAMT_W-1:0].
  - Next state is RUN if cnt!=0, else DONE.
- IDLE, start=0: stay in IDLE; acc holds.
- RUN, each edge:
  - acc<={acc[0], acc[WIDTH-1:1]} (rotate right by 1), cnt<=cnt-1.
  - If cnt==1 at this edge, next state is DONE; else stay in RUN.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- result is driven directly from acc:
  - valid when done=1;
  - holds that value in IDLE until the next accepted start;
  - shows intermediate values in RUN, which must not be consumed.
- Latency: done is high in cycle k+1 after the start edge, where k=b[4:0]. k=0 gives 1 cycle; k=31 gives 32 cycles.
- Rotate amount is taken modulo 32, so b=32 behaves as b=0. Upper bits of b are ignored.
- start while busy=1 (RUN or DONE) is ignored. It is not queued; a and b are not resampled.
- start in the same cycle done is high is ignored. A new start is accepted only from IDLE, so back-to-back operations have at least one IDLE cycle between them.
- busy=(state!=IDLE); done=(state==DONE); both are registered-state decodes.
- Arithmetic is pure bit permutation: no carry, no flags.

Optional Feature:
- Macro: ROR_FAST_EN.
- Defined: in RUN, if cnt>=4, rotate right by 4 and cnt<=cnt-4; otherwise rotate by 1 and cnt<=cnt-1. Transition to DONE when cnt reaches 0 after the update.
  - Latency = floor(k/4) + (k mod 4) + 1.
- Undefined: one position per cycle exactly as above; no 4-step logic synthesised.
- Functional results are identical in both builds.

Test Plan:
- a=0x00000001, b=1, start pulse -> done in cycle 2; result=0x80000000; busy high in cycles 1-2.
- a=0x12345678, b=4 -> result=0x81234567; done at cycle 5 (cycle 2 with ROR_FAST_EN).
- a=0xDEADBEEF, b=0 and separately b=32 -> result=0xDEADBEEF, done in cycle 1 for both.
- a=0x80000000, b=31 -> result=0x00000001; done at cycle 32 (cycle 11 with ROR_FAST_EN). A second start with a=0xFFFFFFFF, b=2 issued in cycle 10 is ignored; result and latency are unchanged.
- a=0x0000000F, b=8, clr asserted in cycle 3 -> next cycle state=IDLE, result=0, busy=0; no done pulse. A fresh start with b=8 then gives result=0x0F000000 with full latency.

Source files
------------

// File: rtl/ror_seq_if.sv
// Start/done handshake bundle for the sequential rotate-right unit.
// master drives the request side; slave returns status and result.
interface ror_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/ror_seq.sv
// Multi-cycle rotate-right unit: rotates a right by b[SHAMT_W-1:0].
// Define ROR_FAST_EN to rotate by 4 per cycle while 4 or more remain.
module ror_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic      clk,
   input logic      clr,
   ror_seq_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   acc, acc_n;
   logic [SHAMT_W-1:0] cnt, cnt_n;
   logic [SHAMT_W-1:0] shamt;

   // upper bits of b are dropped: rotate amount is modulo WIDTH
   assign shamt = bus.b[SHAMT_W-1:0];

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= S_IDLE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               acc_n   = bus.a;
               cnt_n   = shamt;
               state_n = (shamt != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
`ifdef ROR_FAST_EN
            if (cnt >= SHAMT_W'(4)) begin
               acc_n = {acc[3:0], acc[WIDTH-1:4]};
               cnt_n = cnt - SHAMT_W'(4);
            end else begin
               acc_n = {acc[0], acc[WIDTH-1:1]};
               cnt_n = cnt - SHAMT_W'(1);
            end
`else
            acc_n = {acc[0], acc[WIDTH-1:1]};
            cnt_n = cnt - SHAMT_W'(1);
`endif
            if (cnt_n == '0)
               state_n = S_DONE;
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign bus.busy   = (state != S_IDLE);
   assign bus.done   = (state == S_DONE);
   assign bus.result = acc;

endmodule
